// File: rtl/dmem_access_unit_pkg.sv
// dmem_pkg: shared types and lane helpers for the data-memory access unit.
// Contents: dmem_size_t (access size), dmem_state_t (FSM state), lane_be(), store_rep().
// Used by dmem_access_unit and load_align through import dmem_pkg::*.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11   // reserved encoding, behaves as a word
  } dmem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } dmem_state_t;

  // Little-endian byte-lane enables; halfwords pick their lane pair by addr[1] only.
  function automatic logic [3:0] lane_be(input dmem_size_t sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data across every lane so any lane enable picks it up.
  function automatic logic [31:0] store_rep(input dmem_size_t sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// dmem_bus_if: request/acknowledge data-bus bundle between the access unit and memory.
// Ports: bus_req/bus_we/bus_addr/bus_be/bus_wdata (unit -> memory), bus_ack/bus_rdata (memory -> unit).
// Modports: master (access unit side), slave (memory side).
interface dmem_bus_if #(
  parameter int ADDR_W = 32
) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_access_unit_load_align.sv
// load_align: shifts the addressed byte/half lane of a bus word down to bit 0 and extends it.
// Latency: purely combinational. Backpressure: none.
// Ports: i_size, i_signed, i_addr_lo (addr[1:0]), i_word (raw bus word) in; o_data (aligned result) out.
module load_align
  import dmem_pkg::*;
(
  input  dmem_size_t  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: M-stage load/store engine, IDLE -> BUS -> DONE -> IDLE over a req/ack bus.
// Latency: 3 cycles minimum (op seen in IDLE, ack in first BUS cycle, result in DONE).
// Backpressure: stall_mem freezes the pipeline while an op waits in IDLE or sits in BUS.
// Ports: clk, reset (async active-high); mem_*_m/size_m/signed_m/addr_m/wdata_m op inputs;
//        stall_mem, rdata_m outputs; bus (dmem_bus_if.master); align_fault with DMEM_ALIGN_CHECK_EN.
// Build option: define DMEM_ALIGN_CHECK_EN to trap misaligned half/word accesses instead of
//        silently forcing them onto the containing word / addr[1] lane pair.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid_m,
  input  logic              mem_write_m,
  input  logic [1:0]        size_m,
  input  logic              signed_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [31:0]       wdata_m,
  output logic              stall_mem,
  output logic [31:0]       rdata_m,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic              align_fault,
`endif
  dmem_bus_if.master        bus
);

  dmem_state_t       r_state;
  logic [ADDR_W-1:0] r_addr;
  dmem_size_t        r_size;
  logic              r_signed;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  dmem_size_t        w_size;
  logic              w_start;
  logic              w_misalign;
  logic [31:0]       w_load;

  assign w_size  = dmem_size_t'(size_m);
  assign w_start = (r_state == ST_IDLE) && mem_valid_m;

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_fault;

  assign w_misalign = ((w_size == SZ_HALF) && addr_m[0]) ||
                      ((w_size == SZ_WORD || w_size == SZ_WORD_ALT) && (addr_m[1:0] != 2'b00));

  // Set on the IDLE cycle that traps, so it is high for exactly the following DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fault <= 1'b0;
    else       r_fault <= w_start && w_misalign;
  end

  assign align_fault = r_fault;
`else
  assign w_misalign = 1'b0;
`endif

  // Lane selection uses the latched size/addr so it lines up with the acked bus word.
  load_align u_load_align (
    .i_size    (r_size),
    .i_signed  (r_signed),
    .i_addr_lo (r_addr[1:0]),
    .i_word    (bus.bus_rdata),
    .o_data    (w_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_we     <= 1'b0;
      r_be     <= 4'b0000;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_valid_m) begin
            r_addr   <= addr_m;
            r_size   <= w_size;
            r_signed <= signed_m;
            r_we     <= mem_write_m;
            // Bus lanes/data are registered here so they are stable for the whole BUS phase.
            r_be     <= lane_be(w_size, addr_m[1:0]);
            r_wdata  <= store_rep(w_size, wdata_m);
            if (w_misalign) begin
              r_rdata <= 32'h0;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          if (bus.bus_ack) begin
            // Stores leave rdata_m untouched; it only ever carries load results.
            if (!r_we) r_rdata <= w_load;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall_mem     = w_start || (r_state == ST_BUS);
  assign rdata_m       = r_rdata;

  assign bus.bus_req   = (r_state == ST_BUS);
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign bus.bus_be    = r_be;
  assign bus.bus_wdata = r_wdata;

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 SHALL have parameter `ADDR_W`, default 32: byte-address width.
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port `mem_valid_m`, input, 1 bit: M-stage memory op present (MemWriteM | MemtoRegM).
REQ-005 SHALL have port `mem_write_m`, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port `size_m`, input, 2 bits: 00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-007 SHALL have port `signed_m`, input, 1 bit: sign-extend loads (byte/half only).
REQ-008 SHALL have port `addr_m`, input, ADDR_W bits: byte address (ALUResultM).
REQ-009 SHALL have port `wdata_m`, input, 32 bits: store data (WriteDataM), right-justified.
REQ-010 SHALL have port `stall_mem`, output, 1 bit: freeze F/D/E/M pipeline registers.
REQ-011 SHALL have port `rdata_m`, output, 32 bits: aligned, extended load data (ReadDataM).
REQ-012 SHALL have port `bus_req`, output, 1 bit: data-bus request.
REQ-013 SHALL have port `bus_we`, output, 1 bit: bus write enable.
REQ-014 SHALL have port `bus_addr`, output, ADDR_W bits: word-aligned bus address; low 2 bits 0.
REQ-015 SHALL have port `bus_be`, output, 4 bits: byte-lane enables; bit i = bits [8i+7:8i].
REQ-016 SHALL have port `bus_wdata`, output, 32 bits: lane-replicated store data.
REQ-017 SHALL have port `bus_ack`, input, 1 bit: bus completion.
REQ-018 SHALL have port `bus_rdata`, input, 32 bits: bus read data, valid with `bus_ack`.
REQ-019 SHALL have port `align_fault`, output, 1 bit: misaligned-access pulse; present only with `DMEM_ALIGN_CHECK_EN`.

Function
REQ-020 SHALL implement FSM `IDLE` -> `BUS` -> `DONE` -> `IDLE`, using little-endian lanes.
REQ-021 SHALL, in `IDLE` with `mem_valid_m`=1, latch addr/size/signed/we/wdata, assert `stall_mem`, and enter `BUS` next cycle.
REQ-022 SHALL, in `BUS`, hold `bus_req`=1 with stable `bus_addr`/`bus_be`/`bus_we`/`bus_wdata` until the cycle `bus_ack`=1 is sampled.
REQ-023 SHALL, on the ack cycle, register `bus_rdata` and enter `DONE`.
REQ-024 SHALL keep `stall_mem`=1 throughout `IDLE`-with-op and `BUS`.
REQ-025 SHALL, in `DONE`, drive `stall_mem`=0 and `rdata_m` valid for exactly that cycle, then return to `IDLE`; minimum op latency 3 cycles (ack in first `BUS` cycle).
REQ-026 SHALL, with an op present in `IDLE`, leave `rdata_m` at its last value and `stall_mem`=1; with no op present, `stall_mem`=0.
REQ-027 SHALL generate byte enables per size:
- byte: `bus_be` = 1<<addr[1:0];
- half: `bus_be` = 0011 or 1100 by addr[1];
- word: `bus_be` = 1111.
REQ-028 SHALL replicate store data: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word unchanged.
REQ-029 SHALL align loads by shifting the selected lane(s) to bits [7:0]/[15:0], then zero- or sign-extend per `signed_m`; word loads pass through.
REQ-030 SHALL ignore `bus_ack` outside `BUS`.
REQ-031 SHALL ignore `mem_valid_m` outside `IDLE`; an op present in the `DONE` cycle is a new op only when it is still present in the following `IDLE` cycle.

Reset
REQ-032 SHALL, on `reset` assertion (asynchronous, including mid-`BUS`), force state `IDLE`, `bus_req`=0, `stall_mem`=0, `rdata_m`=0, `align_fault`=0, all latched fields 0.
REQ-033 SHALL abandon an in-flight bus transaction on reset and ignore any late `bus_ack`.

Configuration
REQ-034 SHALL, with `DMEM_ALIGN_CHECK_EN` defined, detect misaligned half (addr[0]=1) or word (addr[1:0]!=0) accesses in `IDLE`, skip `BUS` (no `bus_req`), go directly to `DONE` with `rdata_m`=0 and `align_fault`=1 for that cycle; store is dropped.
REQ-035 SHALL, without `DMEM_ALIGN_CHECK_EN`, omit `align_fault`, force misaligned word accesses to the containing word, and select halfword lanes by addr[1] only.

Structure
REQ-036 SHALL place the size encoding (`dmem_size_t`) and FSM state enum (`dmem_state_t`) in shared package `dmem_pkg`.
REQ-037 SHALL implement load lane selection and extension in sub-module `load_align` (combinational; size, signed, addr[1:0], word in; 32-bit result out).

Verification
REQ-038 SHALL cover word store, `addr_m`=0x104, `wdata_m`=0xDEADBEEF, ack in first `BUS` cycle -> `bus_be`=1111, `bus_addr`=0x104, `stall_mem` high 2 cycles, low on cycle 3.
REQ-039 SHALL cover signed byte load, `addr_m`=0x203, `bus_rdata`=0x80112233, ack delayed 4 cycles -> `bus_be`=1000, `rdata_m`=0xFFFFFF80, `bus_req` held 5 cycles.
REQ-040 SHALL cover unsigned half load, `addr_m`=0x302, `bus_rdata`=0xA5B6C7D8 -> `bus_be`=1100, `rdata_m`=0x0000A5B6.
REQ-041 SHALL cover byte store, `addr_m`=0x401, `wdata_m`=0x000000AB -> `bus_be`=0010, `bus_wdata`=0xABABABAB.
REQ-042 SHALL cover reset asserted mid-`BUS`, then `bus_ack` pulsed after release -> `bus_req` and `stall_mem` drop immediately; ack ignored; state `IDLE`.
REQ-043 SHALL cover, with `DMEM_ALIGN_CHECK_EN`, word load at 0x502 -> no `bus_req`; `align_fault`=1 for one cycle; `rdata_m`=0.
